// File: rtl/riscv_pkg.sv
// riscv_pkg: shared width, fetch FSM state encoding and NOP constant
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, WAIT, KILL} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer with flush and fill count
module fetch_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic push, pop;
  // Head reads zero when empty so nothing stale ever leaks to decode
  always_comb begin
    empty = count == '0;
    push = wr_en && !flush && count != (AW+1)'(FIFO_DEPTH);
    pop = rd_en && !flush && !empty;
    rd_data = empty ? '0 : mem[rptr];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wr_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a decode buffer
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pcplus4,
  output logic            misalign_err
);
  import riscv_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [CW-1:0] count;
  logic [2*XLEN-1:0] head;
  logic retire, grant, enq, deq, empty;
  // Issue only when the reply slot is guaranteed to fit in the buffer
  always_comb begin
    retire = imem_rvalid && state != IDLE;
    imem_req = !rst && !redirect_valid && (state == IDLE || retire) &&
               (int'(count) + int'(state != IDLE) < FIFO_DEPTH);
    grant = imem_req && imem_gnt;
    enq = imem_rvalid && state == WAIT && !redirect_valid;
    inst_valid = !empty;
    deq = inst_valid && inst_ready && !redirect_valid;
    misalign_err = !rst && redirect_valid && |redirect_pc[1:0];
    imem_addr = fetch_pc;
    {inst_data, inst_pc} = head;
    inst_pcplus4 = inst_pc + XLEN'(4);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (grant) req_pc <= fetch_pc;
      fetch_pc <= redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} :
                  grant ? fetch_pc + XLEN'(4) : fetch_pc;
      state <= grant ? WAIT : retire ? IDLE :
               (redirect_valid && state == WAIT) ? KILL : state;
    end
  end
  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(2*XLEN)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .wr_en(enq),
    .wr_data({imem_rdata, req_pc}),
    .rd_en(deq),
    .rd_data(head),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a one-cycle-latency memory
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, imem_gnt = 1'b0, rsp_en = 1'b0;
  logic redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic imem_req, imem_rvalid, inst_valid, misalign_err;
  logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc, inst_pcplus4;
  logic pending = 1'b0;
  logic [31:0] paddr = '0;
  int gnt_cnt = 0, g0 = 0, chk_cnt = 0, pass_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory answers the request granted in the previous cycle, gated by rsp_en
  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      pending <= 1'b1;
      paddr <= imem_addr;
      gnt_cnt <= gnt_cnt + 1;
    end else if (imem_rvalid) pending <= 1'b0;
  end
  assign imem_rvalid = pending && rsp_en;
  assign imem_rdata = mdata(paddr);

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pcplus4(inst_pcplus4), .misalign_err(misalign_err)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick; tick;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", inst_valid, 1'b0);
    chk1("rst_misalign", misalign_err, 1'b0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    // streaming: one grant per cycle, deliveries back to back
    imem_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1; rst = 1'b0; #1;
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    tick;
    chk1("no_bypass", inst_valid, 1'b0);
    chk("addr1", imem_addr, 32'h4);
    tick;
    chk1("seq_v0", inst_valid, 1'b1);
    chk("seq_pc0", inst_pc, 32'h0);
    chk("seq_d0", inst_data, mdata(32'h0));
    chk("seq_p4_0", inst_pcplus4, 32'h4);
    tick;
    chk1("seq_v1", inst_valid, 1'b1);
    chk("seq_pc1", inst_pc, 32'h4);
    tick;
    chk1("seq_v2", inst_valid, 1'b1);
    chk("seq_pc2", inst_pc, 32'h8);
    // backpressure: buffer fills to depth and head holds
    rst = 1'b1; inst_ready = 1'b0; tick; tick;
    g0 = gnt_cnt; rst = 1'b0;
    repeat (6) tick;
    chk("bp_pc_mid", inst_pc, 32'h0);
    repeat (14) tick;
    chk("bp_grants", 32'(gnt_cnt - g0), 32'd4);
    chk1("bp_valid", inst_valid, 1'b1);
    chk("bp_pc", inst_pc, 32'h0);
    chk("bp_data", inst_data, mdata(32'h0));
    inst_ready = 1'b1; #1;
    chk("rel_pc0", inst_pc, 32'h0);
    tick; chk("rel_pc1", inst_pc, 32'h4);
    tick; chk("rel_pc2", inst_pc, 32'h8);
    tick; chk("rel_pc3", inst_pc, 32'hC);
    chk("rel_d3", inst_data, mdata(32'hC));
    // redirect with the 0x8 request still outstanding
    rst = 1'b1; tick; tick; rst = 1'b0;
    tick; tick; tick;
    rsp_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk1("redir_req", imem_req, 1'b0);
    tick;
    redirect_valid = 1'b0; rsp_en = 1'b1; #1;
    chk1("flush_valid", inst_valid, 1'b0);
    chk1("kill_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 32'h100);
    tick;
    chk1("drop_valid", inst_valid, 1'b0);
    tick;
    chk1("redir_v", inst_valid, 1'b1);
    chk("redir_pc", inst_pc, 32'h100);
    chk("redir_d", inst_data, mdata(32'h100));
    // misaligned redirect
    tick;
    redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
    chk1("mis_pulse", misalign_err, 1'b1);
    tick;
    redirect_valid = 1'b0; #1;
    chk1("mis_clear", misalign_err, 1'b0);
    chk("mis_addr", imem_addr, 32'h100);
    tick; tick;
    chk1("mis_v", inst_valid, 1'b1);
    chk("mis_pc", inst_pc, 32'h100);
    // reset while waiting; stale reply lands in the first cycle after reset
    inst_ready = 1'b0; rst = 1'b1; tick; tick; rst = 1'b0;
    tick; tick; tick;
    rsp_en = 1'b0; tick;
    rst = 1'b1; tick;
    rst = 1'b0; rsp_en = 1'b1; inst_ready = 1'b1; #1;
    chk1("prst_req", imem_req, 1'b1);
    chk("prst_addr", imem_addr, 32'h0);
    chk1("prst_valid", inst_valid, 1'b0);
    tick;
    chk1("stale_drop", inst_valid, 1'b0);
    tick;
    chk1("prst_v", inst_valid, 1'b1);
    chk("prst_pc", inst_pc, 32'h0);
    chk("prst_d", inst_data, mdata(32'h0));
    // PC wraps at the top of the address space
    tick;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tick;
    redirect_valid = 1'b0; #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick;
    chk("wrap_addr1", imem_addr, 32'h0);
    tick;
    chk1("wrap_v", inst_valid, 1'b1);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_p4", inst_pcplus4, 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
